// File: rtl/fpu_pkg.sv
// Shared FPU constants and the in-flight tag type used by the multiplier arbiter.
package fpu_pkg;

    localparam int FP_W         = 32;
    localparam int NREQ         = 2;
    localparam int FMUL_LATENCY = 1;

    typedef struct packed {
        logic valid;
        logic id;
    } fmul_tag_t;

endpackage

// File: rtl/fmul_tag_pipe.sv
// LATENCY+1 stage shift register of issue tags; the last stage lines up with the
// multiplier output so the result can be steered back to its requester.
import fpu_pkg::*;

module fmul_tag_pipe #(
    parameter int LATENCY = FMUL_LATENCY
) (
    input  logic      clk,
    input  logic      rstn,
    input  fmul_tag_t tag_i,
    output fmul_tag_t tag_o,
    output logic      any_valid_o
);

    fmul_tag_t tag_q [LATENCY+1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i <= LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_i;
            for (int i = 1; i <= LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        any_valid_o = 1'b0;
        for (int i = 0; i <= LATENCY; i++) begin
            any_valid_o = any_valid_o | tag_q[i].valid;
        end
    end

    assign tag_o = tag_q[LATENCY];

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one fixed-latency pipelined multiplier between two
// requesters; results are steered back by a tag that travels alongside the product.
import fpu_pkg::*;

module fmul_arbiter #(
    parameter int LATENCY = FMUL_LATENCY
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_x1,
    input  logic [NREQ*FP_W-1:0] req_x2,
    output logic [FP_W-1:0]      mul_x1,
    output logic [FP_W-1:0]      mul_x2,
    input  logic [FP_W-1:0]      mul_y,
    input  logic                 mul_ovf,
    output logic [NREQ-1:0]      res_valid,
    output logic [FP_W-1:0]      res_y,
    output logic                 res_ovf,
    output logic                 busy
);

    logic            rr_last_q;
    logic            hs;
    logic            gnt_id;
    logic [FP_W-1:0] mul_x1_q, mul_x1_d;
    logic [FP_W-1:0] mul_x2_q, mul_x2_d;
    logic [NREQ-1:0] res_valid_q;
    logic [FP_W-1:0] res_y_q;
    logic            res_ovf_q;
    fmul_tag_t       tag_in;
    fmul_tag_t       tag_out;
    logic            tags_busy;

    // The multiplier never stalls, so a lone valid requester is always granted.
    always_comb begin
        req_ready = '0;
        if (req_valid[0] && (!req_valid[1] || rr_last_q)) begin
            req_ready = 2'b01;
        end else if (req_valid[1]) begin
            req_ready = 2'b10;
        end
    end

    assign hs       = |req_ready;
    assign gnt_id   = req_ready[1];
    assign mul_x1_d = gnt_id ? req_x1[FP_W +: FP_W] : req_x1[0 +: FP_W];
    assign mul_x2_d = gnt_id ? req_x2[FP_W +: FP_W] : req_x2[0 +: FP_W];

    always_comb begin
        tag_in       = '0;
        tag_in.valid = hs;
        tag_in.id    = gnt_id;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_last_q <= 1'b1;
            mul_x1_q  <= '0;
            mul_x2_q  <= '0;
        end else if (hs) begin
            rr_last_q <= gnt_id;
            mul_x1_q  <= mul_x1_d;
            mul_x2_q  <= mul_x2_d;
        end
    end

    fmul_tag_pipe #(
        .LATENCY (LATENCY)
    ) u_tag_pipe (
        .clk         (clk),
        .rstn        (rstn),
        .tag_i       (tag_in),
        .tag_o       (tag_out),
        .any_valid_o (tags_busy)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res_valid_q <= '0;
            res_y_q     <= '0;
            res_ovf_q   <= 1'b0;
        end else if (tag_out.valid) begin
            res_valid_q <= {tag_out.id, ~tag_out.id};
            res_y_q     <= mul_y;
            res_ovf_q   <= mul_ovf;
        end else begin
            res_valid_q <= '0;
        end
    end

    assign mul_x1    = mul_x1_q;
    assign mul_x2    = mul_x2_q;
    assign res_valid = res_valid_q;
    assign res_y     = res_y_q;
    assign res_ovf   = res_ovf_q;
    assign busy      = tags_busy;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Scoreboard bench for fmul_arbiter: a LATENCY=1 instance for the datapath and
// arbitration cases, and a LATENCY=3 instance for the mid-flight reset case.
module tb_fmul_arbiter;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_x1 = '0, req_x2 = '0;
    logic [31:0] mul_x1, mul_x2, mul_y, res_y;
    logic        mul_ovf, res_ovf, busy;
    logic [1:0]  res_valid;

    logic        rstn3 = 1'b1;
    logic [1:0]  req_valid3 = '0;
    logic [1:0]  req_ready3;
    logic [63:0] req3_x1 = '0, req3_x2 = '0;
    logic [31:0] mul3_x1, mul3_x2, mul3_y, res3_y;
    logic        mul3_ovf, res3_ovf, busy3;
    logic [1:0]  res_valid3;

    typedef struct {
        logic [1:0]  rv;
        logic [32:0] e;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   got0 = 0, got1 = 0;
    logic m_rr = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fmul_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .mul_x1(mul_x1), .mul_x2(mul_x2),
        .mul_y(mul_y), .mul_ovf(mul_ovf), .res_valid(res_valid), .res_y(res_y),
        .res_ovf(res_ovf), .busy(busy)
    );

    fmul_arbiter #(.LATENCY(3)) dut3 (
        .clk(clk), .rstn(rstn3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_x1(req3_x1), .req_x2(req3_x2), .mul_x1(mul3_x1), .mul_x2(mul3_x2),
        .mul_y(mul3_y), .mul_ovf(mul3_ovf), .res_valid(res_valid3), .res_y(res3_y),
        .res_ovf(res3_ovf), .busy(busy3)
    );

    // Multiplier model: only the operand pairs used below, returns {ovf, y}.
    function automatic logic [32:0] fmodel(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h7F000000 && b == 32'h7F000000) return {1'b1, 32'h7F800000};
        if (a == 32'h3F800000) return {1'b0, b};
        if (a == 32'h40400000 && b == 32'h40000000) return {1'b0, 32'h40C00000};
        if (a == 32'h3F000000 && b == 32'h3F000000) return {1'b0, 32'h3E800000};
        return 33'h0;
    endfunction

    always @(posedge clk) {mul_ovf, mul_y} <= fmodel(mul_x1, mul_x2);

    logic [32:0] d3 [3];
    always @(posedge clk) begin
        d3[0] <= fmodel(mul3_x1, mul3_x2);
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign {mul3_ovf, mul3_y} = d3[2];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // One cycle of stimulus; e0/e1 are the hand-computed {ovf, y} for each requester.
    task automatic drive(input logic [1:0] v,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [32:0] e0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [32:0] e1);
        logic [1:0] eg;
        exp_t       x;
        @(negedge clk);
        req_valid = v;
        req_x1    = {a1, a0};
        req_x2    = {b1, b0};
        #1;
        if (v == 2'b11) eg = m_rr ? 2'b01 : 2'b10;
        else            eg = v;
        chk("req_ready", {62'd0, req_ready}, {62'd0, eg});
        if (eg != 2'b00) begin
            x.rv  = eg;
            x.e   = eg[1] ? e1 : e0;
            x.cyc = cyc + LAT + 2;
            sbq.push_back(x);
            m_rr = eg[1];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rstn && res_valid !== 2'b00) begin
                if (res_valid[0]) got0++;
                if (res_valid[1]) got1++;
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_res_valid got=%b exp=none", res_valid);
                end else begin
                    x = sbq.pop_front();
                    chk("res_valid", {62'd0, res_valid}, {62'd0, x.rv});
                    chk("res_y", {32'd0, res_y}, {32'd0, x.e[31:0]});
                    chk("res_ovf", {63'd0, res_ovf}, {63'd0, x.e[32]});
                    chk("res_cycle", 64'(cyc), 64'(x.cyc));
                end
            end
        end
    end

    initial begin
        int s0, s1;
        #2;
        rstn  = 1'b0;
        rstn3 = 1'b0;
        #1;
        chk("rst_res_valid", {62'd0, res_valid}, 64'd0);
        chk("rst_res_y", {32'd0, res_y}, 64'd0);
        chk("rst_mul_x1", {32'd0, mul_x1}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ready_idle", {62'd0, req_ready}, 64'd0);
        repeat (2) @(negedge clk);
        rstn  = 1'b1;
        rstn3 = 1'b1;

        // simultaneous requests out of reset: req0 first, then req1
        drive(2'b11, 32'h40400000, 32'h40000000, {1'b0, 32'h40C00000},
                     32'h3F000000, 32'h3F000000, {1'b0, 32'h3E800000});
        drive(2'b10, 32'h40400000, 32'h40000000, {1'b0, 32'h40C00000},
                     32'h3F000000, 32'h3F000000, {1'b0, 32'h3E800000});
        idle(4);

        // single op with busy window and operand hold
        drive(2'b01, 32'h3F800000, 32'h40000000, {1'b0, 32'h40000000}, 0, 0, 0);
        idle(1);
        chk("busy_c1", {63'd0, busy}, 64'd1);
        chk("mul_x1_hold", {32'd0, mul_x1}, 64'h3F800000);
        chk("mul_x2_hold", {32'd0, mul_x2}, 64'h40000000);
        idle(1);
        chk("busy_c2", {63'd0, busy}, 64'd1);
        idle(1);
        chk("busy_c3", {63'd0, busy}, 64'd0);
        idle(2);

        // overflow passthrough on req1
        drive(2'b10, 0, 0, 0, 32'h7F000000, 32'h7F000000, {1'b1, 32'h7F800000});
        idle(4);

        // saturation: grants alternate 0,1,... with 5 results each
        s0 = got0;
        s1 = got1;
        for (int i = 0; i < 10; i++)
            drive(2'b11, 32'h3F800000, 32'h41000000 + i, {1'b0, 32'h41000000 + i},
                         32'h3F800000, 32'h42000000 + i, {1'b0, 32'h42000000 + i});
        idle(4);
        chk("fair_cnt0", 64'(got0 - s0), 64'd5);
        chk("fair_cnt1", 64'(got1 - s1), 64'd5);

        // withdrawal: req1 loses to req0, drops, and keeps its turn afterwards
        drive(2'b11, 32'h3F800000, 32'h40800000, {1'b0, 32'h40800000},
                     32'h3F800000, 32'h40A00000, {1'b0, 32'h40A00000});
        idle(4);
        drive(2'b11, 32'h3F800000, 32'h40800000, {1'b0, 32'h40800000},
                     32'h3F800000, 32'h40A00000, {1'b0, 32'h40A00000});
        idle(4);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

        // LATENCY=3 instance: complete one op so res_y is non-zero
        @(negedge clk);
        req_valid3 = 2'b10;
        req3_x1 = {32'h3F800000, 32'h0};
        req3_x2 = {32'h40000000, 32'h0};
        #1 chk("l3_ready_a", {62'd0, req_ready3}, 64'b10);
        @(negedge clk);
        req_valid3 = 2'b00;
        repeat (5) @(negedge clk);
        chk("l3_res_y", {32'd0, res3_y}, 64'h40000000);
        chk("l3_busy_idle", {63'd0, busy3}, 64'd0);

        // two ops in flight, then async reset mid-cycle
        @(negedge clk);
        req_valid3 = 2'b10;
        @(negedge clk);
        req_valid3 = 2'b01;
        req3_x1 = {32'h3F800000, 32'h3F800000};
        req3_x2 = {32'h40000000, 32'h40400000};
        #1 chk("l3_ready_b", {62'd0, req_ready3}, 64'b01);
        @(negedge clk);
        req_valid3 = 2'b00;
        chk("l3_busy_inflight", {63'd0, busy3}, 64'd1);
        #2 rstn3 = 1'b0;
        #1;
        chk("l3_rst_mul_x1", {32'd0, mul3_x1}, 64'd0);
        chk("l3_rst_mul_x2", {32'd0, mul3_x2}, 64'd0);
        chk("l3_rst_res_valid", {62'd0, res_valid3}, 64'd0);
        chk("l3_rst_res_y", {32'd0, res3_y}, 64'd0);
        chk("l3_rst_res_ovf", {63'd0, res3_ovf}, 64'd0);
        chk("l3_rst_busy", {63'd0, busy3}, 64'd0);
        repeat (2) @(negedge clk);
        rstn3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("l3_no_res_after_rst", {62'd0, res_valid3}, 64'd0);
        end
        req_valid3 = 2'b11;
        #1 chk("l3_first_grant_req0", {62'd0, req_ready3}, 64'b01);
        @(negedge clk);
        req_valid3 = 2'b00;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
